// File: rtl/latch_sample_fifo_pkg.sv
// Shared FIFO definitions: default geometry and a pointer-width helper.
// No logic of its own, so it adds no latency.
// No handshake lives here.
package latch_sample_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Ceiling log2, used to size entry addresses from the depth.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/latch_sample_fifo_ram.sv
// DEPTH x WIDTH storage: one write port and one registered read port.
// Read data appears 1 cycle after rd_en_i; the array itself is never reset.
// No backpressure; the caller only issues accepted reads and writes.
module latch_sample_fifo_ram
    import latch_sample_fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Write the array; it has no reset, so stale data may survive a reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Load the read register on a read; otherwise hold the last value.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // The read register is reset so rd_data reads 0 after a reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/latch_sample_fifo.sv
// Sync FIFO buffering latch q samples; define LATCH_SAMPLE_FIFO_LEVEL_EN to add level_o/almost_full_o.
// Latency: write-to-!empty 1 cycle, rd_en-to-rd_data 1 cycle, min write-to-readout 2 cycles.
// Writes while full and reads while empty are dropped and reported by 1-cycle overflow/underflow pulses.
module latch_sample_fifo
    import latch_sample_fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
`ifdef LATCH_SAMPLE_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]  level_o,
    output logic             almost_full_o
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            rd_valid_q, rd_valid_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic            full;
    logic            empty;
    logic            wr_accept;
    logic            rd_accept;

    // The flags come only from registered pointers, so there is no same-cycle bypass.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign wr_accept = wr_en_i && !full;
    assign rd_accept = rd_en_i && !empty;

    // Compute next pointers and this cycle's result pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = rd_accept;
        overflow_d  = wr_en_i && full;
        underflow_d = rd_en_i && empty;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Register the state; a reset drops all contents and any read in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    latch_sample_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (rd_data_o)
    );

    assign full_o      = full;
    assign empty_o     = empty;
    assign rd_valid_o  = rd_valid_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

`ifdef LATCH_SAMPLE_FIFO_LEVEL_EN
    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(DEPTH - 1);

    // Occupancy is the modular pointer difference; it is 0 after reset because both pointers are 0.
    assign level_o       = wr_ptr_q - rd_ptr_q;
    assign almost_full_o = (level_o >= AF_THRESH);
`endif

endmodule
